// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store/fetch access stage between the multicycle core
// and a ready-handshaked memory bus. It aligns byte lanes, builds write strobes,
// extends load data, stalls the core while an access is in flight, and reports
// misaligned, illegal-size and timed-out accesses.
//
// Handshake: the core raises core_valid and holds the request stable until
// core_done. On the bus side, bus_valid and every bus_* output stay stable from
// the first BUS cycle until the edge where bus_ready is sampled high. That edge
// completes the transfer, and bus_rdata is captured only on it. bus_ready is
// ignored outside BUS.
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  core_valid,
  input  logic                  core_write,
  input  logic [2:0]            core_funct3,
  input  logic [ADDR_WIDTH-1:0] core_address,
  input  logic [31:0]           core_wdata,
  output logic [31:0]           core_rdata,
  output logic                  core_done,
  output logic                  core_error,
  output logic                  core_stall,
  output logic                  bus_valid,
  output logic                  bus_write,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [31:0]           bus_wdata,
  output logic [3:0]            bus_wstrb,
  input  logic                  bus_ready,
  input  logic [31:0]           bus_rdata
);

  // The timer only has to hold values 0 .. TIMEOUT_CYCLES-1.
  localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit            TO_EN  = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TO_LIM = TO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUS   = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_write;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic [TW-1:0]         r_timer;

  logic                  w_illegal;
  logic                  w_misaligned;
  logic                  w_timeout;
  logic [31:0]           w_shifted;
  logic [31:0]           w_load_data;
  logic [3:0]            w_strb;
  logic [31:0]           w_wdata;

  // Classify the incoming request: size codes that do not exist for this
  // direction, and sizes whose address is not naturally aligned.
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    if (core_write) begin
      w_illegal = !(core_funct3 == 3'b000 || core_funct3 == 3'b001 ||
                    core_funct3 == 3'b010);
    end else begin
      w_illegal = (core_funct3 == 3'b011 || core_funct3 == 3'b110 ||
                   core_funct3 == 3'b111);
    end
    case (core_funct3)
      3'b001, 3'b101: w_misaligned = core_address[0];
      3'b010:         w_misaligned = (core_address[1:0] != 2'b00);
      default:        w_misaligned = 1'b0;
    endcase
  end

  // Abort once the bus has been waited on for TIMEOUT_CYCLES cycles.
  assign w_timeout = TO_EN && (r_timer == TO_LIM);

  // Next-state logic for the access sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (core_valid) begin
          w_next = (w_illegal || w_misaligned) ? S_ERROR : S_BUS;
        end
      end
      S_BUS: begin
        if (bus_ready) begin
          w_next = S_DONE;
        end else if (w_timeout) begin
          w_next = S_ERROR;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERROR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Move the addressed lane down to bit 0, then extend according to size/sign.
  always_comb begin
    w_shifted   = bus_rdata >> {r_addr[1:0], 3'b000};
    w_load_data = w_shifted;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_data = {24'h0, w_shifted[7:0]};
      3'b101:  w_load_data = {16'h0, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  // Store strobes and lane-replicated data; any lane the strobe selects
  // already carries the right bytes.
  always_comb begin
    w_strb  = 4'b1111;
    w_wdata = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_strb  = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_strb  = 4'b0011 << {r_addr[1], 1'b0};
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_strb  = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  // Request capture, bus-wait timer and load-data capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_write  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_timer  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (core_valid) begin
            r_write  <= core_write;
            r_funct3 <= core_funct3;
            r_addr   <= core_address;
            r_wdata  <= core_wdata;
            r_timer  <= '0;
          end
        end
        S_BUS: begin
          if (bus_ready) begin
            // Stores leave the last load result in place.
            if (!r_write) begin
              r_rdata <= w_load_data;
            end
          end else if (!w_timeout) begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus_valid   = (r_state == S_BUS);
  assign bus_write   = bus_valid && r_write;
  assign bus_address = {r_addr[ADDR_WIDTH-1:2], 2'b00};
  assign bus_wdata   = w_wdata;
  assign bus_wstrb   = bus_write ? w_strb : 4'b0000;

  assign core_rdata  = r_rdata;
  assign core_done   = (r_state == S_DONE) || (r_state == S_ERROR);
  assign core_error  = (r_state == S_ERROR);
  // Hold the core from the moment it asks until the completion cycle.
  assign core_stall  = !reset &&
                       (((r_state == S_IDLE) && core_valid) || (r_state == S_BUS));

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a driver issues accesses and plays the
// memory, queues carry hand-computed core responses and bus requests, and
// monitors on the falling edge compare what the DUT presents.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        core_valid;
  logic        core_write;
  logic [2:0]  core_funct3;
  logic [31:0] core_address;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_done;
  logic        core_error;
  logic        core_stall;
  logic        bus_valid;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  logic [32:0] exp_q[$];      // {core_error, core_rdata}
  logic [68:0] bus_exp_q[$];  // {write, address, wdata (0 on reads), wstrb}
  logic [68:0] bus_snap;
  logic [68:0] bus_cur;
  logic [68:0] bus_exp;
  logic [32:0] resp_exp;
  logic        in_txn = 1'b0;

  mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .core_valid   (core_valid),
    .core_write   (core_write),
    .core_funct3  (core_funct3),
    .core_address (core_address),
    .core_wdata   (core_wdata),
    .core_rdata   (core_rdata),
    .core_done    (core_done),
    .core_error   (core_error),
    .core_stall   (core_stall),
    .bus_valid    (bus_valid),
    .bus_write    (bus_write),
    .bus_address  (bus_address),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_ready    (bus_ready),
    .bus_rdata    (bus_rdata)
  );

  // Clock.
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [68:0] got, input logic [68:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Every output is zero while reset is held, including stall.
  task automatic check_reset_outputs(input string name);
    check(name, {bus_valid, bus_write, core_done, core_error, core_stall,
                 bus_wstrb, bus_address, bus_wdata, core_rdata}, 69'h0);
  endtask

  // Core-side monitor: stall shape and completion responses.
  always @(negedge clock) begin
    if (!reset) begin
      check("core_stall", core_stall, core_valid & ~core_done);
      if (core_done) begin
        check("bus_idle_at_done", bus_valid, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got error=%b rdata=%h expected no completion",
                   core_error, core_rdata);
        end else begin
          resp_exp = exp_q.pop_front();
          check("core_resp", {core_error, core_rdata}, resp_exp);
        end
      end
    end
  end

  // Bus-side monitor: first cycle of a request against the queue, then stability.
  always @(negedge clock) begin
    if (reset) begin
      in_txn = 1'b0;
    end else if (bus_valid) begin
      bus_cur = {bus_write, bus_address, bus_write ? bus_wdata : 32'h0, bus_wstrb};
      if (!in_txn) begin
        in_txn = 1'b1;
        if (bus_exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_bus: got %h expected no bus request", bus_cur);
        end else begin
          bus_exp = bus_exp_q.pop_front();
          check("bus_request", bus_cur, bus_exp);
        end
        bus_snap = bus_cur;
      end else begin
        check("bus_stable", bus_cur, bus_snap);
      end
    end else begin
      in_txn = 1'b0;
    end
  end

  // Driver: issue one access, answer the bus after 'waits' low cycles, and
  // check the accept-to-done latency.
  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int waits, input logic [31:0] rd,
                        input logic exp_bus, input logic [31:0] exp_baddr,
                        input logic [31:0] exp_bwdata, input logic [3:0] exp_strb,
                        input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
    int lat;
    int w;
    logic got;
    if (exp_bus) bus_exp_q.push_back({wr, exp_baddr, wr ? exp_bwdata : 32'h0, exp_strb});
    exp_q.push_back({exp_err, exp_rd});
    @(posedge clock); #1;
    core_valid   = 1'b1;
    core_write   = wr;
    core_funct3  = f3;
    core_address = addr;
    core_wdata   = wd;
    bus_ready    = 1'b0;
    lat = 0;
    w   = 0;
    got = 1'b0;
    while (!got && lat < 64) begin
      @(posedge clock); #1;
      lat++;
      if (core_done) begin
        got       = 1'b1;
        bus_ready = 1'b0;
      end else if (bus_valid) begin
        if (w >= waits) begin
          bus_ready = 1'b1;
          bus_rdata = rd;
        end else begin
          bus_ready = 1'b0;
          bus_rdata = 32'hFFFF_FFFF;
          w++;
        end
      end else begin
        bus_ready = 1'b0;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no core_done within 64 cycles expected latency %0d", exp_lat);
    end else begin
      check("latency", lat, exp_lat);
    end
    // Request stays high through the completion cycle; drop it after that edge.
    @(posedge clock); #1;
    core_valid = 1'b0;
    bus_ready  = 1'b0;
    bus_rdata  = 32'h5A5A_5A5A;
  endtask

  initial begin
    reset        = 1'b1;
    core_valid   = 1'b1;
    core_write   = 1'b0;
    core_funct3  = 3'b010;
    core_address = 32'h0;
    core_wdata   = 32'h0;
    bus_ready    = 1'b1;
    bus_rdata    = 32'h5A5A_5A5A;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset_state");
    core_valid = 1'b0;
    bus_ready  = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;

    // Loads: word, byte/half with sign and zero extension at several lanes.
    access(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, 2);
    access(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'hFFFFFF80, 2);
    access(1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80112233, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h00000080, 2);
    access(1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80112233, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h00008011, 2);
    access(1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80112233, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'hFFFF8011, 2);
    access(1'b0, 3'b000, 32'h100, 32'h0, 0, 32'h80112233, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h00000033, 2);
    access(1'b0, 3'b001, 32'h100, 32'h0, 0, 32'h80112233, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h00002233, 2);

    // Stores: strobes and lane replication; load data must not change.
    access(1'b1, 3'b000, 32'h201, 32'h123456A5, 0, 32'hFFFFFFFF, 1'b1, 32'h200, 32'hA5A5A5A5, 4'b0010, 1'b0, 32'h00002233, 2);
    access(1'b1, 3'b001, 32'h202, 32'hABCD1234, 1, 32'hFFFFFFFF, 1'b1, 32'h200, 32'h12341234, 4'b1100, 1'b0, 32'h00002233, 3);
    access(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 2, 32'hFFFFFFFF, 1'b1, 32'h204, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h00002233, 4);

    // Misaligned and illegal sizes: error pulse, no bus activity.
    access(1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00002233, 1);
    access(1'b1, 3'b001, 32'h101, 32'h0, 0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00002233, 1);
    access(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00002233, 1);
    access(1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00002233, 1);
    access(1'b0, 3'b101, 32'h101, 32'h0, 0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00002233, 1);

    // Bus waits: three low cycles, then a bus that never answers.
    access(1'b0, 3'b010, 32'h300, 32'h0, 3, 32'h13579BDF, 1'b1, 32'h300, 32'h0, 4'h0, 1'b0, 32'h13579BDF, 5);
    access(1'b0, 3'b010, 32'h304, 32'h0, 1000, 32'h0, 1'b1, 32'h304, 32'h0, 4'h0, 1'b1, 32'h13579BDF, 17);

    // Reset in the second BUS cycle of a pending load.
    bus_exp_q.push_back({1'b0, 32'h400, 32'h0, 4'h0});
    @(posedge clock); #1;
    core_valid   = 1'b1;
    core_write   = 1'b0;
    core_funct3  = 3'b010;
    core_address = 32'h400;
    core_wdata   = 32'h0;
    bus_ready    = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("bus_valid_before_reset", bus_valid, 1'b1);
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid_access");
    @(posedge clock); #1;
    check_reset_outputs("reset_held");
    core_valid = 1'b0;
    reset      = 1'b0;

    access(1'b0, 3'b010, 32'h100, 32'h0, 0, 32'h0BADF00D, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0BADF00D, 2);

    repeat (3) @(posedge clock);
    #1;
    check("resp_queue_drained", exp_q.size(), 0);
    check("bus_queue_drained", bus_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    $fatal(1, "time limit");
  end

endmodule
